// File: rtl/imm_gen_pipe_if.sv
// Upstream/downstream bundle for the immediate-generation stage.
// out_misalign exists only when IMM_MISALIGN_CHK_EN is defined.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_rs1;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic [XLEN-1:0] out_target;
    logic            out_is_ctrl;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_pc;
`ifdef IMM_MISALIGN_CHK_EN
    logic            out_misalign;
`endif

    modport master (
`ifdef IMM_MISALIGN_CHK_EN
        input  out_misalign,
`endif
        output in_valid, in_instr, in_pc, in_rs1, out_ready,
        input  in_ready, out_valid, out_imm, out_type, out_target,
        input  out_is_ctrl, out_instr, out_pc
    );

    modport slave (
`ifdef IMM_MISALIGN_CHK_EN
        output out_misalign,
`endif
        input  in_valid, in_instr, in_pc, in_rs1, out_ready,
        output in_ready, out_valid, out_imm, out_type, out_target,
        output out_is_ctrl, out_instr, out_pc
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV immediate decode + target compute, valid/ready with optional skid entry.
// Define IMM_MISALIGN_CHK_EN to add out_misalign for control-flow targets.
module imm_gen_pipe #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);
    localparam logic [2:0] T_NONE  = 3'd0;
    localparam logic [2:0] T_I     = 3'd1;
    localparam logic [2:0] T_S     = 3'd2;
    localparam logic [2:0] T_B     = 3'd3;
    localparam logic [2:0] T_U     = 3'd4;
    localparam logic [2:0] T_J     = 3'd5;
    localparam logic [2:0] T_SHAMT = 3'd6;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic [XLEN-1:0] target;
        logic            is_ctrl;
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
`ifdef IMM_MISALIGN_CHK_EN
        logic            misalign;
`endif
    } entry_t;

    logic [31:0]     ins;
    logic [6:0]      op;
    logic            is_shift;
    logic [XLEN-1:0] jalr_sum;
    entry_t          dec;
    entry_t          out_q;
    logic            out_v;
    logic            in_ready;
    logic            accept;

    assign ins      = bus.in_instr;
    assign op       = ins[6:0];
    assign is_shift = (ins[13:12] == 2'b01);  // funct3 001 or 101

    always_comb begin
        dec       = '0;
        dec.instr = ins;
        dec.pc    = bus.in_pc;
        jalr_sum  = '0;
        case (op)
            OP_LUI, OP_AUIPC: begin
                dec.typ = T_U;
                dec.imm = XLEN'($signed({ins[31:12], 12'b0}));
            end
            OP_JAL: begin
                dec.typ = T_J;
                dec.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            OP_JALR, OP_LOAD, OP_SYSTEM: begin
                dec.typ = T_I;
                dec.imm = XLEN'($signed(ins[31:20]));
            end
            OP_IMM: begin
                if (is_shift) begin
                    dec.typ = T_SHAMT;
                    dec.imm = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
                end else begin
                    dec.typ = T_I;
                    dec.imm = XLEN'($signed(ins[31:20]));
                end
            end
            OP_IMM32: begin
                // Word-immediate ops only exist on RV64; on RV32 this opcode decodes as NONE.
                if (XLEN == 64) begin
                    if (is_shift) begin
                        dec.typ = T_SHAMT;
                        dec.imm = XLEN'(ins[24:20]);
                    end else begin
                        dec.typ = T_I;
                        dec.imm = XLEN'($signed(ins[31:20]));
                    end
                end
            end
            OP_STORE: begin
                dec.typ = T_S;
                dec.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
            end
            OP_BRANCH: begin
                dec.typ = T_B;
                dec.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            default: ;
        endcase

        case (op)
            OP_JAL, OP_BRANCH, OP_AUIPC: dec.target = bus.in_pc + dec.imm;
            OP_JALR: begin
                jalr_sum   = bus.in_rs1 + dec.imm;
                dec.target = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
        dec.is_ctrl = (op == OP_JAL) || (op == OP_JALR) || (op == OP_BRANCH);
`ifdef IMM_MISALIGN_CHK_EN
        dec.misalign = dec.is_ctrl && (dec.target[1:0] != 2'b00);
`endif
    end

    assign accept = bus.in_valid && in_ready && !flush;

    generate
        if (SKID_EN) begin : g_skid
            entry_t skid_q;
            logic   skid_v;
            logic   rdy_q;

            // rdy_q tracks !skid_v one edge late, so upstream never sees a combinational path.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q  <= '0;
                    out_v  <= 1'b0;
                    skid_q <= '0;
                    skid_v <= 1'b0;
                    rdy_q  <= 1'b0;
                end else if (flush) begin
                    out_v  <= 1'b0;
                    skid_v <= 1'b0;
                    rdy_q  <= 1'b1;
                end else if (!out_v || bus.out_ready) begin
                    rdy_q <= 1'b1;
                    if (skid_v) begin
                        out_q  <= skid_q;
                        out_v  <= 1'b1;
                        skid_v <= 1'b0;
                    end else begin
                        out_v <= accept;
                        if (accept) out_q <= dec;
                    end
                end else if (accept) begin
                    skid_q <= dec;
                    skid_v <= 1'b1;
                    rdy_q  <= 1'b0;
                end else begin
                    rdy_q <= !skid_v;
                end
            end

            assign in_ready = rdy_q;
        end else begin : g_noskid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q <= '0;
                    out_v <= 1'b0;
                end else if (flush) begin
                    out_v <= 1'b0;
                end else if (accept) begin
                    out_q <= dec;
                    out_v <= 1'b1;
                end else if (bus.out_ready) begin
                    out_v <= 1'b0;
                end
            end

            assign in_ready = !out_v || bus.out_ready;
        end
    endgenerate

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_v;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_type    = out_q.typ;
    assign bus.out_target  = out_q.target;
    assign bus.out_is_ctrl = out_q.is_ctrl;
    assign bus.out_instr   = out_q.instr;
    assign bus.out_pc      = out_q.pc;
`ifdef IMM_MISALIGN_CHK_EN
    assign bus.out_misalign = out_q.misalign;
`endif
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate-generation stage between fetch and execute.
- Takes a full 32-bit RV instruction, its PC and rs1 operand.
- Decodes the immediate format from the opcode, sign-extends it to XLEN, and computes the control-flow or AUIPC target.
- Presents results through a valid/ready interface with a 2-entry skid buffer, so upstream sees fully registered backpressure.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Sets immediate/target width and shamt width (5 bits at 32, 6 bits at 64).
- SKID_EN, 1. When 1, a 2-entry skid buffer is used and in_ready is registered. When 0, single register and in_ready = !out_valid || out_ready.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept
- in_instr  in  32  full instruction word
- in_pc  in  XLEN  instruction PC
- in_rs1  in  XLEN  rs1 operand (JALR base)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  sign/zero-extended immediate
- out_type  out  3  0=NONE 1=I 2=S 3=B 4=U 5=J 6=SHAMT
- out_target  out  XLEN  computed target, 0 if not applicable
- out_is_ctrl  out  1  1 for JAL/JALR/BRANCH
- out_instr  out  32  pass-through instruction
- out_pc  out  XLEN  pass-through PC

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, all data outputs 0, skid entry invalid.
  - in_ready=1 on the first edge after release.
  - Reset mid-transfer drops all held entries.
- Decode on instr[6:0]:
  - LUI 0110111 / AUIPC 0010111 -> U: imm={instr[31:12],12'b0} sign-extended to XLEN.
  - JAL 1101111 -> J: {instr[31],instr[19:12],instr[20],instr[30:21],0}.
  - JALR 1100111 / LOAD 0000011 / SYSTEM 1110011 -> I: instr[31:20].
  - OP-IMM 0010011 (and OP-IMM-32 0011011 when XLEN=64) -> I, except funct3 001/101 -> SHAMT.
    - SHAMT imm = zero-extended instr[24:20] at XLEN 32; instr[25:20] at XLEN 64 for OP-IMM; instr[24:20] for OP-IMM-32.
  - STORE 0100011 -> S: {instr[31:25],instr[11:7]}.
  - BRANCH 1100011 -> B: {instr[31],instr[7],instr[30:25],instr[11:8],0}.
  - Any other opcode -> NONE, imm=0, target=0.
- All non-SHAMT immediates are sign-extended from their MSB to XLEN.
- Targets, modulo 2^XLEN (wrap, no carry out):
  - B/J/AUIPC: pc+imm.
  - JALR: (rs1+imm) with bit0 forced to 0.
  - All others: 0.
- Latency: exactly 1 cycle from an accepted input (in_valid&&in_ready) to out_valid.
- Ordering: strict in-order; no entry duplicated or lost.
- Handshake:
  - An output is held stable while out_valid&&!out_ready.
  - SKID_EN=1: in_ready is a register, = !skid_valid.
    - An input accepted while the output is stalled goes to the skid entry.
    - When the output drains, the skid entry moves to the output and in_ready rises the next cycle.
  - Simultaneous accept and drain with an empty skid: the new entry replaces the output directly.
- flush (priority over in_valid):
  - Next edge clears out_valid and the skid entry.
  - Input presented in the same cycle is discarded.
  - in_ready=1 the following cycle.

Optional Feature:
- Macro: IMM_MISALIGN_CHK_EN.
- Defined: adds output port out_misalign (1 bit), registered with the entry, reset 0.
  - =1 when out_is_ctrl and target[1:0]!=0. BRANCH and JAL are checked whether taken or not.
  - Downstream uses it to raise an instruction-address-misaligned exception.
- Not defined: port absent, no check logic.

Test Plan:
- JAL 0x0080006F, pc=0x100 -> next cycle out_valid=1, out_type=5, out_imm=0x8, out_target=0x108, out_is_ctrl=1.
- BEQ x0,x0,-4 0xFE000EE3, pc=0x200 -> out_type=3, out_imm=0xFFFFFFFC, out_target=0x1FC. With XLEN=64: out_imm=0xFFFFFFFFFFFFFFFC.
- JALR 0x003280E7, rs1=0x1000 -> out_type=1, out_imm=3, out_target=0x1002. With IMM_MISALIGN_CHK_EN: out_misalign=1.
- SRAI 0x4030D093 -> out_type=6, out_imm=3 (not 0x403). LUI 0x123450B7 -> out_imm=0x12345000, out_target=0.
- Backpressure: out_ready=0 for 3 cycles with 3 back-to-back inputs.
  - Output holds the first entry; the second is skidded.
  - in_ready=0 from the cycle after the second accept.
  - Release out_ready -> entries emerge in order; the third is accepted only after in_ready returns.
- flush asserted with a stalled output, a full skid entry and in_valid=1 -> next cycle out_valid=0 and in_ready=1; none of the three entries ever appears. rst_n pulsed low mid-stream -> outputs 0 immediately.
